bus_endpoint_fifo: RTL and testbench

Device-side endpoint for the shared bus generator/arbiter.
- Presents a TX FIFO to the bus: pndng, D_pop, pop. The bus pops packets from it.
- Receives bus deliveries into an RX FIFO: push, D_push.
- Filters received packets by destination ID and exposes a simple host read/write interface.
- One instance per bus device slot. Replaces the behavioural FIFOs of the bench drivers with synthesizable RTL.

---
 rtl/bus_endpoint_fifo_pkg.sv | 26 ++
 rtl/bus_endpoint_fifo_if.sv | 19 +
 rtl/bus_endpoint_fifo_ep_fifo.sv | 64 ++++++
 rtl/bus_endpoint_fifo.sv | 95 +++++++++
 tb/tb_bus_endpoint_fifo.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_endpoint_fifo_pkg.sv
// Shared definitions for the bus endpoint FIFO slice.
//   ID_W / BROADCAST_ID : destination-ID field width and broadcast address
//   PKT_MAX_W           : widest packet dest_of() can take apart
//   cnt_width()         : occupancy counter width for a given FIFO depth
//   cnt_t               : occupancy counter type at the default depth
//   dest_of()           : extracts the destination ID (top ID_W bits) of a packet
package bus_ep_pkg;

  localparam int unsigned ID_W          = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
  localparam int unsigned PKT_MAX_W     = 256;
  localparam int unsigned DEFAULT_DEPTH = 8;

  typedef logic [$clog2(DEFAULT_DEPTH+1)-1:0] cnt_t;

  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d + 1);
  endfunction

  // pkt is the zero-extended packet, w its real width
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned       w);
    return pkt[w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_endpoint_fifo_if.sv
// Bus-side connection of one endpoint slot.
//   pndng  : TX FIFO non-empty
//   D_pop  : TX head packet (0 when empty)
//   pop    : bus consumes TX head
//   push   : bus delivers D_push
//   D_push : delivered packet
// master = bus generator/arbiter side, slave = endpoint side.
interface bus_endpoint_fifo_if #(
  parameter int unsigned pckg_sz = 16
);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport master (input pndng, D_pop, output pop, push, D_push);
  modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_endpoint_fifo_ep_fifo.sv
// Synchronous first-word fall-through FIFO used for both endpoint directions.
//   clk, reset : clock, async active-high reset
//   wr, wdata  : write request and data
//   rd         : consume head (ignored when empty)
//   rdata      : head entry, 0 when empty
//   full/empty : derived from the registered count only
//   count      : occupancy
//   ovf        : one-cycle pulse after a write was dropped
module ep_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [width-1:0]           wdata,
  input  logic                       rd,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       ovf
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             do_rd;
  logic             do_wr;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(depth));
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign rdata = empty ? '0 : mem[rd_ptr];

  // A write into a full FIFO still fits when the head leaves on the same edge.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
      ovf_q <= wr && !do_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bus_endpoint_fifo.sv
// Device-side endpoint for the shared bus: TX FIFO popped by the bus, RX FIFO
// filled by bus deliveries, and a host read/write interface.
//   clk, reset             : clock, async active-high reset
//   bus (slave modport)    : pndng, D_pop, pop, push, D_push
//   tx_wr, tx_data         : host packet write
//   tx_full, tx_count      : TX status
//   rx_rd, rx_data         : host consumes RX head (rx_data 0 when empty)
//   rx_empty, rx_count     : RX status
//   tx_ovf, rx_ovf         : one-cycle drop pulses
//   misroute_cnt           : saturating count of pushes dropped by the ID filter
// Build option BUS_EP_ADDR_FILTER_EN: when defined, pushes are accepted only for
// dest == id or dest == broadcast; when undefined, every push is accepted and
// misroute_cnt is 0.
module bus_endpoint_fifo
  import bus_ep_pkg::*;
#(
  parameter int unsigned     pckg_sz   = 16,
  parameter int unsigned     depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic                       clk,
  input  logic                       reset,
  bus_endpoint_fifo_if.slave         bus,
  input  logic                       tx_wr,
  input  logic [pckg_sz-1:0]         tx_data,
  output logic                       tx_full,
  input  logic                       rx_rd,
  output logic [pckg_sz-1:0]         rx_data,
  output logic                       rx_empty,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic [7:0]                 misroute_cnt
);

  logic tx_empty;
  logic rx_full_unused;
  logic addr_ok;

  ep_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr),
    .wdata (tx_data),
    .rd    (bus.pop),
    .rdata (bus.D_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .ovf   (tx_ovf)
  );

  assign bus.pndng = !tx_empty;

  // rx_ovf comes from the FIFO itself, so it only fires for address-accepted pushes.
  ep_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk   (clk),
    .reset (reset),
    .wr    (bus.push && addr_ok),
    .wdata (bus.D_push),
    .rd    (rx_rd),
    .rdata (rx_data),
    .full  (rx_full_unused),
    .empty (rx_empty),
    .count (rx_count),
    .ovf   (rx_ovf)
  );

`ifdef BUS_EP_ADDR_FILTER_EN
  logic [ID_W-1:0] dest;
  logic [7:0]      misroute_q;

  assign dest    = dest_of(PKT_MAX_W'(bus.D_push), pckg_sz);
  assign addr_ok = (dest == id) || (dest == broadcast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_q <= '0;
    end else if (bus.push && !addr_ok && (misroute_q != '1)) begin
      misroute_q <= misroute_q + 8'd1;
    end
  end

  assign misroute_cnt = misroute_q;
`else
  logic [2*ID_W-1:0] filter_ids_unused;

  assign filter_ids_unused = {id, broadcast};
  assign addr_ok           = 1'b1;
  assign misroute_cnt      = '0;
`endif

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
module tb_bus_endpoint_fifo;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef BUS_EP_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_wr;
  logic [W-1:0]  tx_data;
  logic          tx_full;
  logic          rx_rd;
  logic [W-1:0]  rx_data;
  logic          rx_empty;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          tx_ovf;
  logic          rx_ovf;
  logic [7:0]    misroute_cnt;

  bus_endpoint_fifo_if #(.pckg_sz(W)) bus ();

  bus_endpoint_fifo #(
    .pckg_sz   (W),
    .depth     (DEPTH),
    .id        (8'h03),
    .broadcast (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .tx_ovf       (tx_ovf),
    .rx_ovf       (rx_ovf),
    .misroute_cnt (misroute_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] tx_exp[$];
  logic [W-1:0] rx_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every packet the DUT hands out against the queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.pop && bus.pndng) begin
        if (tx_exp.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_pop: got %0h with no packet expected", bus.D_pop);
        end else begin
          check("tx_pop", 32'(bus.D_pop), 32'(tx_exp.pop_front()));
        end
      end
      if (rx_rd && !rx_empty) begin
        if (rx_exp.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_read: got %0h with no packet expected", rx_data);
        end else begin
          check("rx_read", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [W-1:0] d, input bit acc);
    tx_wr   = 1'b1;
    tx_data = d;
    if (acc) tx_exp.push_back(d);
    step();
    tx_wr = 1'b0;
  endtask

  task automatic rx_push(input logic [W-1:0] d, input bit acc);
    bus.push   = 1'b1;
    bus.D_push = d;
    if (acc) rx_exp.push_back(d);
    step();
    bus.push = 1'b0;
  endtask

  task automatic pop_n(input int unsigned n);
    bus.pop = 1'b1;
    repeat (n) step();
    bus.pop = 1'b0;
  endtask

  task automatic read_n(input int unsigned n);
    rx_rd = 1'b1;
    repeat (n) step();
    rx_rd = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_pndng"},    32'(bus.pndng),  32'd0);
    check({tag, "_D_pop"},    32'(bus.D_pop),  32'd0);
    check({tag, "_tx_full"},  32'(tx_full),    32'd0);
    check({tag, "_rx_empty"}, 32'(rx_empty),   32'd1);
    check({tag, "_rx_data"},  32'(rx_data),    32'd0);
    check({tag, "_tx_count"}, 32'(tx_count),   32'd0);
    check({tag, "_rx_count"}, 32'(rx_count),   32'd0);
    check({tag, "_tx_ovf"},   32'(tx_ovf),     32'd0);
    check({tag, "_rx_ovf"},   32'(rx_ovf),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    tx_wr      = 1'b0;
    tx_data    = '0;
    rx_rd      = 1'b0;
    bus.pop    = 1'b0;
    bus.push   = 1'b0;
    bus.D_push = '0;
    step();
    step();
    reset = 1'b0;
    step();
    check_idle_state("reset");
    check("reset_misroute", 32'(misroute_cnt), 32'd0);

    // Three TX packets, head visible the cycle after the first write
    tx_write(16'h0312, 1'b1);
    check("tx1_pndng", 32'(bus.pndng), 32'd1);
    check("tx1_D_pop", 32'(bus.D_pop), 32'h0312);
    tx_write(16'h0234, 1'b1);
    tx_write(16'h0156, 1'b1);
    check("tx3_count", 32'(tx_count), 32'd3);
    pop_n(3);
    check("tx3_pndng_after", 32'(bus.pndng), 32'd0);
    check("tx3_D_pop_after", 32'(bus.D_pop), 32'd0);

    // TX fill, overflow, write+pop while full
    for (int i = 0; i < 8; i++) tx_write(16'h1000 + 16'(i), 1'b1);
    check("txfill_full",  32'(tx_full),  32'd1);
    check("txfill_count", 32'(tx_count), 32'd8);
    tx_write(16'hDEAD, 1'b0);
    check("txovf_pulse", 32'(tx_ovf),   32'd1);
    check("txovf_count", 32'(tx_count), 32'd8);
    step();
    check("txovf_clear", 32'(tx_ovf), 32'd0);
    bus.pop = 1'b1;
    tx_write(16'h2000, 1'b1);
    bus.pop = 1'b0;
    check("txwrpop_count", 32'(tx_count), 32'd8);
    check("txwrpop_ovf",   32'(tx_ovf),   32'd0);
    pop_n(8);
    check("txdrain_pndng", 32'(bus.pndng), 32'd0);

    // Write and pop together while empty: pop ignored
    bus.pop = 1'b1;
    tx_write(16'h0ABC, 1'b1);
    bus.pop = 1'b0;
    check("txempty_wrpop_count", 32'(tx_count), 32'd1);
    check("txempty_wrpop_head",  32'(bus.D_pop), 32'h0ABC);
    pop_n(1);
    check("txempty_wrpop_drain", 32'(tx_count), 32'd0);

    // RX address filter (id = 3)
    rx_push(16'h03AA, 1'b1);
    rx_push(16'hFF55, 1'b1);
    rx_push(16'h0777, !FILT);
    check("rxfilt_count",    32'(rx_count),     FILT ? 32'd2 : 32'd3);
    check("rxfilt_misroute", 32'(misroute_cnt), FILT ? 32'd1 : 32'd0);
    check("rxfilt_head",     32'(rx_data),      32'h03AA);
    read_n(FILT ? 2 : 3);
    check("rxfilt_empty", 32'(rx_empty), 32'd1);
    read_n(1);
    check("rxrd_empty_count", 32'(rx_count), 32'd0);
    check("rxrd_empty_data",  32'(rx_data),  32'd0);

    // RX fill, overflow, push+read while full, order across pointer wrap
    for (int i = 0; i < 8; i++) rx_push(16'h0340 + 16'(i), 1'b1);
    check("rxfill_count", 32'(rx_count), 32'd8);
    rx_push(16'h03EE, 1'b0);
    check("rxovf_pulse", 32'(rx_ovf),   32'd1);
    check("rxovf_count", 32'(rx_count), 32'd8);
    step();
    check("rxovf_clear", 32'(rx_ovf), 32'd0);
    rx_rd = 1'b1;
    rx_push(16'h03F0, 1'b1);
    rx_rd = 1'b0;
    check("rxpushrd_count", 32'(rx_count), 32'd8);
    check("rxpushrd_ovf",   32'(rx_ovf),   32'd0);
    read_n(8);
    check("rxdrain_empty", 32'(rx_empty), 32'd1);

    // Reset mid-traffic drops everything
    for (int i = 0; i < 5; i++) tx_write(16'h0500 + 16'(i), 1'b1);
    for (int i = 0; i < 3; i++) rx_push(16'h0360 + 16'(i), 1'b1);
    check("prereset_tx_count", 32'(tx_count), 32'd5);
    check("prereset_rx_count", 32'(rx_count), 32'd3);
    reset = 1'b1;
    tx_exp.delete();
    rx_exp.delete();
    step();
    check_idle_state("midreset");
    check("midreset_misroute", 32'(misroute_cnt), 32'd0);
    reset = 1'b0;
    step();

    // 300 foreign-ID pushes: counter saturates (filter) or RX fills (no filter)
    bus.push = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.D_push = 16'h0700 | 16'(i[7:0]);
      if (!FILT && i < 8) rx_exp.push_back(bus.D_push);
      step();
    end
    bus.push = 1'b0;
    check("sat_misroute", 32'(misroute_cnt), FILT ? 32'd255 : 32'd0);
    check("sat_rx_count", 32'(rx_count),     FILT ? 32'd0 : 32'd8);
    read_n(FILT ? 0 : 8);

    step();
    check("tx_leftover", 32'(tx_exp.size()), 32'd0);
    check("rx_leftover", 32'(rx_exp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
